// File: rtl/branch_flag_unit.sv
// Architectural flag register and conditional-branch resolver.
// Forwards EX flags into ID, stalls on load-use flag hazards.
module branch_flag_unit #(
  parameter int PC_W      = 10,
  parameter int FLUSH_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [5:0]      ex_opcode,
  input  logic            ex_load_pend,
  input  logic            ca_in,
  input  logic            cb_in,
  input  logic            za_in,
  input  logic            zb_in,
  input  logic            na_in,
  input  logic            nb_in,
  input  logic            id_valid,
  input  logic [5:0]      id_opcode,
  input  logic [PC_W-1:0] id_target,
  output logic            take_branch,
  output logic [PC_W-1:0] branch_pc,
  output logic            stall_id,
  output logic            flush_if,
  output logic [5:0]      flags_q
);

  localparam logic [5:0] ADDA  = 6'h00;
  localparam logic [5:0] ADDB  = 6'h01;
  localparam logic [5:0] ADDCA = 6'h02;
  localparam logic [5:0] ADDCB = 6'h03;
  localparam logic [5:0] SUBA  = 6'h04;
  localparam logic [5:0] SUBB  = 6'h05;
  localparam logic [5:0] SUBCA = 6'h06;
  localparam logic [5:0] SUBCB = 6'h07;
  localparam logic [5:0] ANDA  = 6'h08;
  localparam logic [5:0] ANDB  = 6'h09;
  localparam logic [5:0] ANDCA = 6'h0A;
  localparam logic [5:0] ANDCB = 6'h0B;
  localparam logic [5:0] ORA   = 6'h0C;
  localparam logic [5:0] ORB   = 6'h0D;
  localparam logic [5:0] ORCA  = 6'h0E;
  localparam logic [5:0] ORCB  = 6'h0F;
  localparam logic [5:0] ASLA  = 6'h10;
  localparam logic [5:0] ASRA  = 6'h11;
  localparam logic [5:0] LDA   = 6'h12;
  localparam logic [5:0] LDB   = 6'h13;
  localparam logic [5:0] LDCA  = 6'h14;
  localparam logic [5:0] LDCB  = 6'h15;
  localparam logic [5:0] BRA   = 6'h18;
  localparam logic [5:0] BAEQ  = 6'h19;
  localparam logic [5:0] BANE  = 6'h1A;
  localparam logic [5:0] BACS  = 6'h1B;
  localparam logic [5:0] BACC  = 6'h1C;
  localparam logic [5:0] BAMI  = 6'h1D;
  localparam logic [5:0] BAPL  = 6'h1E;
  localparam logic [5:0] BBEQ  = 6'h1F;
  localparam logic [5:0] BBNE  = 6'h20;
  localparam logic [5:0] BBCS  = 6'h21;
  localparam logic [5:0] BBCC  = 6'h22;
  localparam logic [5:0] BBMI  = 6'h23;
  localparam logic [5:0] BBPL  = 6'h24;
  localparam logic [5:0] JMP   = 6'h25;
  localparam logic [5:0] JSR   = 6'h26;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  // Extra flush cycles beyond the taken-branch cycle itself.
  localparam bit         FLUSH_ON = (FLUSH_CYC > 1);
  localparam logic [1:0] CNT_INIT =
    FLUSH_ON ? 2'(FLUSH_CYC - 2) : 2'd0;

  logic [1:0] state;
  logic [1:0] state_d;
  logic [1:0] cnt;
  logic [1:0] cnt_d;

  logic alu_a;
  logic alu_b;
  logic ld_a;
  logic ld_b;
  logic wr_ca;
  logic wr_cb;
  logic wr_zna;
  logic wr_znb;

  logic ca_e;
  logic cb_e;
  logic za_e;
  logic zb_e;
  logic na_e;
  logic nb_e;

  logic cond;
  logic uses_a;
  logic uses_b;
  logic hazard;
  logic taken_now;

  logic take;
  logic stall;
  logic flush;

  // Classify the EX opcode into its flag-write group.
  always_comb begin
    alu_a = 1'b0;
    alu_b = 1'b0;
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    case (ex_opcode)
      ADDA, ADDCA, ANDA, ANDCA, ORA, ORCA,
      ASLA, ASRA, SUBA, SUBCA:             alu_a = 1'b1;
      ADDB, ADDCB, ANDB, ANDCB, ORB, ORCB,
      SUBB, SUBCB:                         alu_b = 1'b1;
      LDA, LDCA:                           ld_a  = 1'b1;
      LDB, LDCB:                           ld_b  = 1'b1;
      default: ;
    endcase
  end

  // Load data is not yet valid while pending, so no write or forward.
  assign wr_ca  = ex_valid & ~ex_load_pend & alu_a;
  assign wr_cb  = ex_valid & ~ex_load_pend & alu_b;
  assign wr_zna = ex_valid & ~ex_load_pend & (alu_a | ld_a);
  assign wr_znb = ex_valid & ~ex_load_pend & (alu_b | ld_b);

  assign ca_e = wr_ca  ? ca_in : flags_q[5];
  assign cb_e = wr_cb  ? cb_in : flags_q[4];
  assign za_e = wr_zna ? za_in : flags_q[3];
  assign zb_e = wr_znb ? zb_in : flags_q[2];
  assign na_e = wr_zna ? na_in : flags_q[1];
  assign nb_e = wr_znb ? nb_in : flags_q[0];

  // Evaluate the ID branch condition against the effective flags.
  always_comb begin
    cond   = 1'b0;
    uses_a = 1'b0;
    uses_b = 1'b0;
    case (id_opcode)
      BAEQ: begin cond = za_e;  uses_a = 1'b1; end
      BANE: begin cond = ~za_e; uses_a = 1'b1; end
      BACS: begin cond = ca_e;  uses_a = 1'b1; end
      BACC: begin cond = ~ca_e; uses_a = 1'b1; end
      BAMI: begin cond = na_e;  uses_a = 1'b1; end
      BAPL: begin cond = ~na_e; uses_a = 1'b1; end
      BBEQ: begin cond = zb_e;  uses_b = 1'b1; end
      BBNE: begin cond = ~zb_e; uses_b = 1'b1; end
      BBCS: begin cond = cb_e;  uses_b = 1'b1; end
      BBCC: begin cond = ~cb_e; uses_b = 1'b1; end
      BBMI: begin cond = nb_e;  uses_b = 1'b1; end
      BBPL: begin cond = ~nb_e; uses_b = 1'b1; end
      BRA, JMP, JSR: cond = 1'b1;
      default: ;
    endcase
  end

  assign hazard = id_valid & ex_valid & ex_load_pend &
                  ((uses_a & ld_a) | (uses_b & ld_b));

  assign taken_now = id_valid & cond;

  // Branch-resolution state machine and flush counter next-state.
  always_comb begin
    take    = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (hazard) begin
          stall   = 1'b1;
          state_d = WAIT;
        end else if (taken_now) begin
          take    = 1'b1;
          flush   = 1'b1;
          state_d = FLUSH_ON ? FLUSH : IDLE;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        state_d = IDLE;
        if (taken_now) begin
          take    = 1'b1;
          flush   = 1'b1;
          state_d = FLUSH_ON ? FLUSH : IDLE;
          cnt_d   = CNT_INIT;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (cnt == 2'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Outputs are forced low while reset is asserted.
  assign take_branch = rst_n & take;
  assign stall_id    = rst_n & stall;
  assign flush_if    = rst_n & flush;
  assign branch_pc   = (rst_n & take) ? id_target : '0;

  // State and flush counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Architectural flag register, written per group as EX retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 6'd0;
    end else begin
      if (wr_ca)  flags_q[5] <= ca_in;
      if (wr_cb)  flags_q[4] <= cb_in;
      if (wr_zna) flags_q[3] <= za_in;
      if (wr_znb) flags_q[2] <= zb_in;
      if (wr_zna) flags_q[1] <= na_in;
      if (wr_znb) flags_q[0] <= nb_in;
    end
  end

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed bench for branch_flag_unit: vector table
// plus load-use, flush and reset sequences.
module tb_branch_flag_unit;

  localparam logic [5:0] ADDA  = 6'h00;
  localparam logic [5:0] ADDB  = 6'h01;
  localparam logic [5:0] SUBA  = 6'h04;
  localparam logic [5:0] SUBCB = 6'h07;
  localparam logic [5:0] ANDCA = 6'h0A;
  localparam logic [5:0] ORB   = 6'h0D;
  localparam logic [5:0] ASLA  = 6'h10;
  localparam logic [5:0] LDA   = 6'h12;
  localparam logic [5:0] LDB   = 6'h13;
  localparam logic [5:0] BRA   = 6'h18;
  localparam logic [5:0] BAEQ  = 6'h19;
  localparam logic [5:0] BANE  = 6'h1A;
  localparam logic [5:0] BACS  = 6'h1B;
  localparam logic [5:0] BAPL  = 6'h1E;
  localparam logic [5:0] BBEQ  = 6'h1F;
  localparam logic [5:0] BBCC  = 6'h22;
  localparam logic [5:0] BBMI  = 6'h23;
  localparam logic [5:0] JMP   = 6'h25;
  localparam logic [5:0] JSR   = 6'h26;
  localparam logic [5:0] NOP   = 6'h3F;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ex_valid;
  logic [5:0] ex_opcode;
  logic       ex_load_pend;
  logic       ca_in, cb_in, za_in, zb_in, na_in, nb_in;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [9:0] id_target;
  logic       take_branch;
  logic [9:0] branch_pc;
  logic       stall_id;
  logic       flush_if;
  logic [5:0] flags_q;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  branch_flag_unit #(.PC_W(10), .FLUSH_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_load_pend(ex_load_pend),
    .ca_in(ca_in), .cb_in(cb_in),
    .za_in(za_in), .zb_in(zb_in),
    .na_in(na_in), .nb_in(nb_in),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .id_target(id_target),
    .take_branch(take_branch), .branch_pc(branch_pc),
    .stall_id(stall_id), .flush_if(flush_if),
    .flags_q(flags_q)
  );

  typedef struct packed {
    logic       ev;
    logic [5:0] eop;
    logic       lp;
    logic [5:0] fin;
    logic       iv;
    logic [5:0] iop;
    logic [9:0] tgt;
    logic       e_take;
    logic [9:0] e_pc;
    logic       e_stall;
    logic       e_flush;
    logic [5:0] e_flags;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input logic ev, input logic [5:0] eop,
                       input logic lp, input logic [5:0] fin,
                       input logic iv, input logic [5:0] iop,
                       input logic [9:0] tgt);
    ex_valid     = ev;
    ex_opcode    = eop;
    ex_load_pend = lp;
    {ca_in, cb_in, za_in, zb_in, na_in, nb_in} = fin;
    id_valid     = iv;
    id_opcode    = iop;
    id_target    = tgt;
  endtask

  task automatic idle_in();
    drive(1'b0, NOP, 1'b0, 6'd0, 1'b0, NOP, 10'd0);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, ADDB,  1'b0, 6'b001100, 1'b1, BAEQ, 10'h155,
                 1'b0, 10'h000, 1'b0, 1'b0, 6'b000100};
    vecs[1]  = '{1'b1, SUBA,  1'b0, 6'b001000, 1'b1, BAEQ, 10'h2A0,
                 1'b1, 10'h2A0, 1'b0, 1'b1, 6'b001100};
    vecs[2]  = '{1'b1, ADDA,  1'b0, 6'b100010, 1'b1, BACS, 10'h011,
                 1'b1, 10'h011, 1'b0, 1'b1, 6'b100110};
    vecs[3]  = '{1'b0, ADDA,  1'b0, 6'b011001, 1'b1, BAEQ, 10'h3FF,
                 1'b0, 10'h000, 1'b0, 1'b0, 6'b100110};
    vecs[4]  = '{1'b1, LDB,   1'b0, 6'b010001, 1'b1, BBMI, 10'h0F0,
                 1'b1, 10'h0F0, 1'b0, 1'b1, 6'b100011};
    vecs[5]  = '{1'b1, ORB,   1'b0, 6'b010000, 1'b1, BBCC, 10'h123,
                 1'b0, 10'h000, 1'b0, 1'b0, 6'b110010};
    vecs[6]  = '{1'b1, NOP,   1'b0, 6'b001111, 1'b1, BAPL, 10'h200,
                 1'b0, 10'h000, 1'b0, 1'b0, 6'b110010};
    vecs[7]  = '{1'b1, ASLA,  1'b0, 6'b001000, 1'b0, BRA,  10'h0C3,
                 1'b0, 10'h000, 1'b0, 1'b0, 6'b011000};
    vecs[8]  = '{1'b1, ANDCA, 1'b1, 6'b100010, 1'b1, BRA,  10'h3C0,
                 1'b1, 10'h3C0, 1'b0, 1'b1, 6'b011000};
    vecs[9]  = '{1'b1, LDA,   1'b1, 6'b000010, 1'b1, JMP,  10'h07F,
                 1'b1, 10'h07F, 1'b0, 1'b1, 6'b011000};
    vecs[10] = '{1'b1, SUBCB, 1'b0, 6'b000100, 1'b0, BBEQ, 10'h0AA,
                 1'b0, 10'h000, 1'b0, 1'b0, 6'b001100};
    vecs[11] = '{1'b0, NOP,   1'b0, 6'b110011, 1'b1, BANE, 10'h001,
                 1'b0, 10'h000, 1'b0, 1'b0, 6'b001100};
    vecs[12] = '{1'b0, NOP,   1'b0, 6'b000000, 1'b1, JSR,  10'h100,
                 1'b1, 10'h100, 1'b0, 1'b1, 6'b001100};

    // Reset with a live unconditional branch in ID.
    rst_n = 1'b0;
    drive(1'b1, ADDA, 1'b0, 6'b111111, 1'b1, BRA, 10'h155);
    #3;
    chk("rst_flags", 32'(flags_q), 32'h0);
    chk("rst_take", 32'(take_branch), 32'h0);
    chk("rst_flush", 32'(flush_if), 32'h0);
    chk("rst_stall", 32'(stall_id), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_flags", 32'(flags_q), 32'h0);
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();

    // Table of single-cycle vectors, each followed by a bubble.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].ev, vecs[i].eop, vecs[i].lp, vecs[i].fin,
            vecs[i].iv, vecs[i].iop, vecs[i].tgt);
      @(negedge clk);
      chk($sformatf("v%0d_take", i), 32'(take_branch),
          32'(vecs[i].e_take));
      chk($sformatf("v%0d_pc", i), 32'(branch_pc), 32'(vecs[i].e_pc));
      chk($sformatf("v%0d_stall", i), 32'(stall_id),
          32'(vecs[i].e_stall));
      chk($sformatf("v%0d_flush", i), 32'(flush_if),
          32'(vecs[i].e_flush));
      next_cyc();
      chk($sformatf("v%0d_flags", i), 32'(flags_q),
          32'(vecs[i].e_flags));
      idle_in();
      next_cyc();
    end

    // Load-use: flags 001100, EX LDA pending, ID BANE.
    drive(1'b1, LDA, 1'b1, 6'b000000, 1'b1, BANE, 10'h234);
    @(negedge clk);
    chk("lu_stall", 32'(stall_id), 32'h1);
    chk("lu_take0", 32'(take_branch), 32'h0);
    chk("lu_flush0", 32'(flush_if), 32'h0);
    next_cyc();
    chk("lu_flags_hold", 32'(flags_q), 32'b001100);
    drive(1'b1, LDA, 1'b0, 6'b000010, 1'b1, BANE, 10'h234);
    @(negedge clk);
    chk("lu_wait_stall", 32'(stall_id), 32'h0);
    chk("lu_wait_take", 32'(take_branch), 32'h1);
    chk("lu_wait_pc", 32'(branch_pc), 32'h234);
    next_cyc();
    chk("lu_flags_commit", 32'(flags_q), 32'b000110);
    drive(1'b0, NOP, 1'b0, 6'd0, 1'b1, BANE, 10'h234);
    @(negedge clk);
    chk("lu_fl_take", 32'(take_branch), 32'h0);
    chk("lu_fl_flush", 32'(flush_if), 32'h1);
    next_cyc();
    idle_in();
    @(negedge clk);
    chk("lu_idle_flush", 32'(flush_if), 32'h0);
    next_cyc();

    // Two-cycle flush squashes an ID branch in its second cycle.
    drive(1'b0, NOP, 1'b0, 6'd0, 1'b1, BRA, 10'h050);
    @(negedge clk);
    chk("fl_take", 32'(take_branch), 32'h1);
    chk("fl_pc", 32'(branch_pc), 32'h050);
    chk("fl_flush1", 32'(flush_if), 32'h1);
    next_cyc();
    drive(1'b1, SUBA, 1'b0, 6'b001000, 1'b1, BAEQ, 10'h060);
    @(negedge clk);
    chk("fl_squash_take", 32'(take_branch), 32'h0);
    chk("fl_flush2", 32'(flush_if), 32'h1);
    next_cyc();
    chk("fl_flags", 32'(flags_q), 32'b001100);
    drive(1'b0, NOP, 1'b0, 6'd0, 1'b1, BAEQ, 10'h060);
    @(negedge clk);
    chk("fl_after_take", 32'(take_branch), 32'h1);
    chk("fl_after_pc", 32'(branch_pc), 32'h060);
    next_cyc();
    idle_in();
    next_cyc();

    // Reset asserted mid-flush.
    drive(1'b0, NOP, 1'b0, 6'd0, 1'b1, BRA, 10'h3A5);
    @(negedge clk);
    chk("rf_take", 32'(take_branch), 32'h1);
    next_cyc();
    idle_in();
    @(negedge clk);
    chk("rf_flush_pre", 32'(flush_if), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rf_flags", 32'(flags_q), 32'h0);
    chk("rf_flush", 32'(flush_if), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();
    @(negedge clk);
    chk("rf_idle_flush", 32'(flush_if), 32'h0);
    next_cyc();
    drive(1'b0, NOP, 1'b0, 6'd0, 1'b1, BRA, 10'h111);
    @(negedge clk);
    chk("rf_idle_take", 32'(take_branch), 32'h1);
    chk("rf_idle_pc", 32'(branch_pc), 32'h111);
    next_cyc();
    idle_in();
    next_cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
